// File: rtl/maf_pkg.sv
// Shared definitions for the FMA normalization path: mode decode, default
// widths and the per-lane shift/exponent record passed between stages.
package maf_pkg;

    localparam int SUM_W_DEF = 64;
    localparam int LZ_W_DEF  = 7;
    localparam int EXP_W_DEF = 11;
    localparam int HALF_W_DEF = SUM_W_DEF / 2;

    typedef struct packed {
        logic [LZ_W_DEF-1:0]  shift;
        logic [EXP_W_DEF-1:0] expo;
        logic                 tiny;
        logic                 zero;
    } lane_t;

    // Same decode as the LZA correction stage: only 000 and 010 run full width.
    function automatic logic is_full_mode(input logic [2:0] cont);
        return (cont == 3'b000) || (cont == 3'b010);
    endfunction

endpackage

// File: rtl/maf_lane_shamt.sv
// Per-lane shift amount and exponent adjustment. i_narrow halves the
// saturation limit so a full-width instance can also serve a half lane.
module maf_lane_shamt #(
    parameter int LANE_W = 64,
    parameter int LZ_W   = 7,
    parameter int EXP_W  = 11
) (
    input  logic [LANE_W-1:0] i_sum,
    input  logic              i_narrow,
    input  logic [LZ_W-1:0]   i_lz,
    input  logic              i_rev,
    input  logic [EXP_W-1:0]  i_exp,
    output logic [LZ_W-1:0]   o_shift,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_tiny,
    output logic              o_zero
);

    localparam int CW = 32;

    logic [CW-1:0] w_req;
    logic [CW-1:0] w_max;
    logic [CW-1:0] w_req_sat;
    logic [CW-1:0] w_exp;

    always_comb begin
        w_req     = CW'(i_lz) + CW'(i_rev);
        w_max     = i_narrow ? CW'(LANE_W / 2 - 1) : CW'(LANE_W - 1);
        w_req_sat = (w_req > w_max) ? w_max : w_req;
        w_exp     = CW'(i_exp);

        o_shift = '0;
        o_exp   = '0;
        o_tiny  = 1'b0;
        o_zero  = 1'b0;
        if (i_sum == '0) begin
            o_zero = 1'b1;
        end else if (w_req_sat >= w_exp) begin
            // Exponent would reach zero or below: stop one short and flag tiny.
            o_tiny  = 1'b1;
            o_shift = (w_exp == '0) ? '0 : LZ_W'(w_exp - 1);
        end else begin
            o_shift = LZ_W'(w_req_sat);
            o_exp   = EXP_W'(w_exp - w_req_sat);
        end
    end

endmodule

// File: rtl/maf_normalize_stage.sv
// Two-stage normalization: stage 1 derives per-lane shift/exponent, stage 2
// applies the lane-local left shifts and registers every output.
module maf_normalize_stage
    import maf_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int LZ_W  = LZ_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_cont,
    input  logic [SUM_W-1:0] in_sum,
    input  logic [LZ_W-1:0]  in_lz_lo,
    input  logic [LZ_W-1:0]  in_lz_hi,
    input  logic [1:0]       in_revising,
    input  logic [EXP_W-1:0] in_exp_lo,
    input  logic [EXP_W-1:0] in_exp_hi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [EXP_W-1:0] out_exp_lo,
    output logic [EXP_W-1:0] out_exp_hi,
    output logic [2:0]       out_cont,
    output logic [1:0]       out_tiny,
    output logic [1:0]       out_zero
);

    localparam int HALF_W = SUM_W / 2;

    // Handshake: a beat moves on valid&&ready at either port. Stage 2 loads
    // when empty or draining; stage 1 loads when empty or moving into stage 2,
    // so accept and drain in one cycle keep full rate.
    logic w_s2_en;
    logic w_s1_en;

    logic             r_s1_valid;
    logic [2:0]       r_s1_cont;
    logic [SUM_W-1:0] r_s1_sum;
    lane_t            r_s1_lo;
    lane_t            r_s1_hi;

    logic             r_s2_valid;
    logic [SUM_W-1:0] r_out_sum;
    logic [EXP_W-1:0] r_out_exp_lo;
    logic [EXP_W-1:0] r_out_exp_hi;
    logic [2:0]       r_out_cont;
    logic [1:0]       r_out_tiny;
    logic [1:0]       r_out_zero;

    logic             w_full;
    logic [SUM_W-1:0] w_lo_sum;
    logic [LZ_W-1:0]  w_lo_shift;
    logic [EXP_W-1:0] w_lo_exp;
    logic             w_lo_tiny;
    logic             w_lo_zero;
    logic [LZ_W-1:0]  w_hi_shift;
    logic [EXP_W-1:0] w_hi_exp;
    logic             w_hi_tiny;
    logic             w_hi_zero;
    lane_t            w_lo_lane;
    lane_t            w_hi_lane;

    assign w_s2_en  = !r_s2_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en;

    assign w_full   = is_full_mode(in_cont);
    assign w_lo_sum = w_full ? in_sum : {{HALF_W{1'b0}}, in_sum[HALF_W-1:0]};

    maf_lane_shamt #(.LANE_W(SUM_W), .LZ_W(LZ_W), .EXP_W(EXP_W)) u_lane_lo (
        .i_sum    (w_lo_sum),
        .i_narrow (!w_full),
        .i_lz     (in_lz_lo),
        .i_rev    (in_revising[0]),
        .i_exp    (in_exp_lo),
        .o_shift  (w_lo_shift),
        .o_exp    (w_lo_exp),
        .o_tiny   (w_lo_tiny),
        .o_zero   (w_lo_zero)
    );

    maf_lane_shamt #(.LANE_W(HALF_W), .LZ_W(LZ_W), .EXP_W(EXP_W)) u_lane_hi (
        .i_sum    (in_sum[SUM_W-1:HALF_W]),
        .i_narrow (1'b0),
        .i_lz     (in_lz_hi),
        .i_rev    (in_revising[1]),
        .i_exp    (in_exp_hi),
        .o_shift  (w_hi_shift),
        .o_exp    (w_hi_exp),
        .o_tiny   (w_hi_tiny),
        .o_zero   (w_hi_zero)
    );

    always_comb begin
        w_lo_lane = '{shift: w_lo_shift, expo: w_lo_exp, tiny: w_lo_tiny, zero: w_lo_zero};
        w_hi_lane = '0;
        if (!w_full) begin
            w_hi_lane = '{shift: w_hi_shift, expo: w_hi_exp, tiny: w_hi_tiny, zero: w_hi_zero};
        end
    end

    logic [SUM_W-1:0]  w_full_shifted;
    logic [HALF_W-1:0] w_hi_shifted;
    logic [HALF_W-1:0] w_lo_shifted;
    logic [SUM_W-1:0]  w_norm;

    // Lanes shift independently in dual mode so no bit crosses the boundary.
    always_comb begin
        w_full_shifted = r_s1_sum << r_s1_lo.shift;
        w_hi_shifted   = r_s1_sum[SUM_W-1:HALF_W] << r_s1_hi.shift;
        w_lo_shifted   = r_s1_sum[HALF_W-1:0] << r_s1_lo.shift;
        w_norm         = is_full_mode(r_s1_cont) ? w_full_shifted
                                                 : {w_hi_shifted, w_lo_shifted};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_cont  <= '0;
            r_s1_sum   <= '0;
            r_s1_lo    <= '0;
            r_s1_hi    <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_cont <= in_cont;
                r_s1_sum  <= in_sum;
                r_s1_lo   <= w_lo_lane;
                r_s1_hi   <= w_hi_lane;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_out_sum    <= '0;
            r_out_exp_lo <= '0;
            r_out_exp_hi <= '0;
            r_out_cont   <= '0;
            r_out_tiny   <= '0;
            r_out_zero   <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sum    <= w_norm;
                r_out_exp_lo <= r_s1_lo.expo;
                r_out_exp_hi <= r_s1_hi.expo;
                r_out_cont   <= r_s1_cont;
                r_out_tiny   <= {r_s1_hi.tiny, r_s1_lo.tiny};
                r_out_zero   <= {r_s1_hi.zero, r_s1_lo.zero};
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_sum    = r_out_sum;
    assign out_exp_lo = r_out_exp_lo;
    assign out_exp_hi = r_out_exp_hi;
    assign out_cont   = r_out_cont;
    assign out_tiny   = r_out_tiny;
    assign out_zero   = r_out_zero;

endmodule

// File: tb/tb_maf_normalize_stage.sv
// Bench for maf_normalize_stage: directed and random beats, scoreboard queue
// filled by the driver from a spec-level model and drained by a monitor.
module tb_maf_normalize_stage;

    localparam int PW = 64 + 11 + 11 + 3 + 2 + 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_cont;
    logic [63:0] in_sum;
    logic [6:0]  in_lz_lo;
    logic [6:0]  in_lz_hi;
    logic [1:0]  in_revising;
    logic [10:0] in_exp_lo;
    logic [10:0] in_exp_hi;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic [10:0] out_exp_lo;
    logic [10:0] out_exp_hi;
    logic [2:0]  out_cont;
    logic [1:0]  out_tiny;
    logic [1:0]  out_zero;

    logic [PW-1:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;
    int rdy_mode = 0;

    maf_normalize_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cont     (in_cont),
        .in_sum      (in_sum),
        .in_lz_lo    (in_lz_lo),
        .in_lz_hi    (in_lz_hi),
        .in_revising (in_revising),
        .in_exp_lo   (in_exp_lo),
        .in_exp_hi   (in_exp_hi),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_exp_lo  (out_exp_lo),
        .out_exp_hi  (out_exp_hi),
        .out_cont    (out_cont),
        .out_tiny    (out_tiny),
        .out_zero    (out_zero)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer readiness changes just after the rising edge only.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic void lane_model(input longint unsigned v, input int w, input int lz,
                                       input int rv, input int e, output longint unsigned res,
                                       output int eo, output bit tiny, output bit zero);
        int req;
        int sh;
        longint unsigned mask;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        tiny = 1'b0;
        zero = 1'b0;
        if ((v & mask) == 0) begin
            res  = 0;
            eo   = 0;
            zero = 1'b1;
        end else begin
            req = lz + rv;
            if (req > w - 1) req = w - 1;
            if (req >= e) begin
                sh   = (e == 0) ? 0 : e - 1;
                eo   = 0;
                tiny = 1'b1;
            end else begin
                sh = req;
                eo = e - req;
            end
            res = ((v & mask) << sh) & mask;
        end
    endfunction

    function automatic logic [PW-1:0] model(input logic [2:0] c, input logic [63:0] s,
                                            input int lzl, input int lzh, input logic [1:0] rv,
                                            input int el, input int eh);
        longint unsigned r_lo, r_hi;
        int e_lo, e_hi;
        bit t_lo, t_hi, z_lo, z_hi;
        logic [63:0] sum;
        if (c == 3'b000 || c == 3'b010) begin
            lane_model(s, 64, lzl, int'(rv[0]), el, r_lo, e_lo, t_lo, z_lo);
            sum  = r_lo;
            e_hi = 0;
            t_hi = 1'b0;
            z_hi = 1'b0;
        end else begin
            lane_model(s >> 32, 32, lzh, int'(rv[1]), eh, r_hi, e_hi, t_hi, z_hi);
            lane_model(s & 64'h0000_0000_FFFF_FFFF, 32, lzl, int'(rv[0]), el, r_lo, e_lo, t_lo, z_lo);
            sum = (r_hi << 32) | r_lo;
        end
        return {sum, 11'(e_lo), 11'(e_hi), c, t_hi, t_lo, z_hi, z_lo};
    endfunction

    // ---------------- checks ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: a beat transfers at the next rising edge when valid&&ready here.
    logic [PW-1:0] held;
    logic          held_v = 1'b0;
    always @(negedge clk) begin
        logic [PW-1:0] got;
        logic [PW-1:0] want;
        got = {out_sum, out_exp_lo, out_exp_hi, out_cont, out_tiny, out_zero};
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                n_vec++;
                if (got !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable got=%h want=%h", got, held);
                end
            end
            held_v = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat got=%h want=none", got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            n_fail++;
                            $display("FAIL out_beat got=%h want=%h", got, want);
                        end
                    end
                end else begin
                    held_v = 1'b1;
                    held   = got;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [2:0] c, input logic [63:0] s, input int lzl, input int lzh,
                        input logic [1:0] rv, input int el, input int eh);
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        in_cont     = c;
        in_sum      = s;
        in_lz_lo    = 7'(lzl);
        in_lz_hi    = 7'(lzh);
        in_revising = rv;
        in_exp_lo   = 11'(el);
        in_exp_hi   = 11'(eh);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(c, s, lzl, lzh, rv, el, eh));
                return;
            end
        end
        n_vec++;
        n_fail++;
        $display("FAIL accept_timeout got=stalled want=in_ready");
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
    endtask

    task automatic rand_lane(input int w, output longint unsigned v, output int k);
        longint unsigned r;
        if ($urandom_range(0, 15) == 0) begin
            v = 0;
            k = w;
        end else begin
            r = {$urandom, $urandom};
            k = $urandom_range(0, w - 1);
            if (w == 64) v = (r | 64'h8000_0000_0000_0000) >> k;
            else         v = ((r & 64'hFFFF_FFFF) | 64'h8000_0000) >> k;
        end
    endtask

    function automatic int pick_lz(input int k);
        int lz;
        if ($urandom_range(0, 7) == 0) return $urandom_range(0, 127);
        lz = k - int'($urandom_range(0, 1));
        return (lz < 0) ? 0 : lz;
    endfunction

    function automatic int pick_exp();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 40);
        return $urandom_range(41, 2047);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_cont     = '0;
        in_sum      = '0;
        in_lz_lo    = '0;
        in_lz_hi    = '0;
        in_revising = '0;
        in_exp_lo   = '0;
        in_exp_hi   = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_exp", 64'({out_exp_lo, out_exp_hi}), 64'd0);
        chk("rst_out_flags", 64'({out_cont, out_tiny, out_zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed beats from the test plan.
        send(3'b000, 64'h0000_0001_0000_0000, 31, 0, 2'b00, 100, 0);
        send(3'b000, 64'h0000_0001_0000_0000, 30, 0, 2'b01, 100, 0);
        send(3'b001, 64'h0000_8000_4000_0000, 1, 15, 2'b10, 5, 20);
        send(3'b000, 64'h0000_0001_0000_0000, 31, 0, 2'b00, 10, 0);
        send(3'b000, 64'h0, 5, 0, 2'b00, 50, 0);
        send(3'b010, 64'h0, 5, 9, 2'b11, 0, 7);
        send(3'b111, 64'h0000_0001_0000_0000, 127, 127, 2'b11, 2047, 2047);
        idle();
        drain();

        // Latency: result visible two edges after transfer.
        send(3'b000, 64'h0000_0000_0000_00F0, 56, 0, 2'b00, 1000, 0);
        idle();
        #5;
        chk("latency_1cyc_not_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("latency_2cyc_valid", 64'(out_valid), 64'd1);
        drain();

        // Backpressure: two beats fill the pipe, third waits, all emerge in order.
        @(posedge clk);
        #1;
        rdy_mode  = 2;
        out_ready = 1'b0;
        send(3'b000, 64'h0000_0000_0000_0001, 63, 0, 2'b00, 500, 0);
        send(3'b001, 64'h0001_0000_0000_0100, 20, 15, 2'b00, 300, 300);
        fork
            send(3'b100, 64'h0000_00FF_FFFF_FFFF, 0, 24, 2'b01, 3, 60);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                repeat (3) @(posedge clk);
                #1;
                rdy_mode  = 0;
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Random traffic with random consumer backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            logic [2:0] c;
            longint unsigned v_a, v_b;
            int k_a, k_b;
            logic [63:0] s;
            c = 3'($urandom_range(0, 7));
            if (c == 3'b000 || c == 3'b010) begin
                rand_lane(64, v_a, k_a);
                s = v_a;
                send(c, s, pick_lz(k_a), $urandom_range(0, 127), 2'($urandom_range(0, 3)),
                     pick_exp(), pick_exp());
            end else begin
                rand_lane(32, v_a, k_a);
                rand_lane(32, v_b, k_b);
                s = (v_b << 32) | v_a;
                send(c, s, pick_lz(k_a), pick_lz(k_b), 2'($urandom_range(0, 3)),
                     pick_exp(), pick_exp());
            end
            if ($urandom_range(0, 9) == 0) idle();
        end
        idle();
        rdy_mode = 0;
        drain();

        // Reset with beats in flight: everything is discarded.
        send(3'b000, 64'h0000_0000_0001_0000, 47, 0, 2'b00, 200, 0);
        send(3'b011, 64'h0000_0001_0000_0001, 31, 31, 2'b00, 100, 100);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_sum", out_sum, 64'd0);
        chk("midrst_out_exp", 64'({out_exp_lo, out_exp_hi}), 64'd0);
        chk("midrst_out_flags", 64'({out_cont, out_tiny, out_zero}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_stale", 64'(out_valid), 64'd0);

        // Pipeline still works after the mid-flight reset.
        send(3'b000, 64'h0000_0001_0000_0000, 30, 0, 2'b01, 100, 0);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Hard stop if something wedges beyond all task-level budgets.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "timeout");
    end

endmodule
